// File: rtl/normalize_seq_if.sv
// Bus bundle for normalize_seq: input handshake (sum/exponent/sign) and the
// result handshake with its status outputs.
interface normalize_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] sum_in;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] mant_out;
    logic [7:0]  exp_out;
    logic        sign_out;
    logic [7:0]  norm_shift;
    logic        carry_out;
    logic        zero_flag;
    logic        underflow;
    logic        overflow;

    modport slave (
        input  in_valid, sum_in, exp_in, sign_in, out_ready,
        output in_ready, out_valid, mant_out, exp_out, sign_out,
        output norm_shift, carry_out, zero_flag, underflow, overflow
    );

    modport master (
        output in_valid, sum_in, exp_in, sign_in, out_ready,
        input  in_ready, out_valid, mant_out, exp_out, sign_out,
        input  norm_shift, carry_out, zero_flag, underflow, overflow
    );
endinterface

// File: rtl/normalize_seq.sv
// Post-add normalizer, IDLE -> NORM -> DONE. Default build shifts left one bit per
// NORM cycle; defining NORM_LZC_EN selects a single-cycle leading-zero count and barrel shift.
module normalize_seq (
    input  logic           clk,
    input  logic           rst_n,
    normalize_seq_if.slave bus,
    output logic [1:0]     state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_NORM = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [24:0] sum_q, sum_d;
    logic [7:0]  exp_q, exp_d;
    logic [7:0]  shift_q, shift_d;
    logic [22:0] mant_q, mant_d;
    logic [7:0]  expo_q, expo_d;
    logic        sign_q, sign_d;
    logic        carry_q, carry_d;
    logic        zero_q, zero_d;
    logic        unf_q, unf_d;
    logic        ovf_q, ovf_d;

`ifdef NORM_LZC_EN
    logic [4:0]  msb;
    logic [7:0]  need, lim, amt;
    logic [22:0] shifted;

    // Shift is capped at exp-1 so the exponent bottoms out at 1; any excess is underflow.
    always_comb begin
        msb = '0;
        for (int i = 0; i < 24; i++) begin
            if (sum_q[i]) msb = i[4:0];
        end
        need    = 8'd23 - {3'b000, msb};
        lim     = (exp_q == 8'd0) ? 8'd0 : exp_q - 8'd1;
        amt     = (need > lim) ? lim : need;
        shifted = 23'(sum_q << amt);
    end
`endif

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, so they are never high together.
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        exp_d   = exp_q;
        shift_d = shift_q;
        mant_d  = mant_q;
        expo_d  = expo_q;
        sign_d  = sign_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        unf_d   = unf_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    sum_d   = bus.sum_in;
                    exp_d   = bus.exp_in;
                    sign_d  = bus.sign_in;
                    shift_d = '0;
                    state_d = S_NORM;
                end
            end
            S_NORM: begin
                state_d = S_DONE;
                carry_d = 1'b0;
                zero_d  = 1'b0;
                unf_d   = 1'b0;
                ovf_d   = 1'b0;
                if (sum_q == '0) begin
                    zero_d = 1'b1;
                    mant_d = '0;
                    expo_d = '0;
                end else if (exp_q == 8'hFF || (sum_q[24] && exp_q == 8'hFE)) begin
                    ovf_d   = 1'b1;
                    carry_d = sum_q[24];
                    mant_d  = '0;
                    expo_d  = 8'hFF;
                end else if (sum_q[24]) begin
                    carry_d = 1'b1;
                    mant_d  = sum_q[23:1];
                    expo_d  = exp_q + 8'd1;
                end
`ifdef NORM_LZC_EN
                else begin
                    mant_d  = shifted;
                    shift_d = amt;
                    if (need > lim) begin
                        unf_d  = 1'b1;
                        expo_d = '0;
                    end else begin
                        expo_d = exp_q - amt;
                    end
                end
`else
                else if (sum_q[23]) begin
                    mant_d = sum_q[22:0];
                    expo_d = exp_q;
                end else if (exp_q <= 8'd1) begin
                    unf_d  = 1'b1;
                    mant_d = sum_q[22:0];
                    expo_d = '0;
                end else begin
                    state_d = S_NORM;
                    sum_d   = {sum_q[23:0], 1'b0};
                    exp_d   = exp_q - 8'd1;
                    shift_d = (shift_q >= 8'd23) ? 8'd23 : shift_q + 8'd1;
                end
`endif
            end
            S_DONE: begin
                if (bus.out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sum_q   <= '0;
            exp_q   <= '0;
            shift_q <= '0;
            mant_q  <= '0;
            expo_q  <= '0;
            sign_q  <= 1'b0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            exp_q   <= exp_d;
            shift_q <= shift_d;
            mant_q  <= mant_d;
            expo_q  <= expo_d;
            sign_q  <= sign_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.mant_out   = mant_q;
    assign bus.exp_out    = expo_q;
    assign bus.sign_out   = sign_q;
    assign bus.norm_shift = shift_q;
    assign bus.carry_out  = carry_q;
    assign bus.zero_flag  = zero_q;
    assign bus.underflow  = unf_q;
    assign bus.overflow   = ovf_q;
    assign state_o        = state_q;
endmodule

// File: tb/tb_normalize_seq.sv
// Self-checking bench for normalize_seq: directed corner cases, randomized sums and
// exponents against an arithmetic reference model, and a mid-NORM reset.
module tb_normalize_seq;
    logic       clk;
    logic       rst_n;
    logic [1:0] state_dbg;
    int         n_checks;
    int         n_errors;

    normalize_seq_if bus();

    normalize_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus.slave),
        .state_o (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [22:0] mant;
        logic [7:0]  expo;
        logic [7:0]  shift;
        logic        carry;
        logic        zero;
        logic        unf;
        logic        ovf;
    } res_t;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Result computed directly from the value of the sum: position of its top bit
    // decides how far it must move, limited by how far the exponent can drop.
    function automatic res_t model(input logic [24:0] s, input logic [7:0] e);
        res_t   r;
        int     top, need, lim, sh;
        longint v;
        r = '0;
        v = longint'(s);
        if (v == 0) begin
            r.zero = 1'b1;
        end else if (e == 8'd255 || (v >= 64'd16777216 && e == 8'd254)) begin
            r.ovf   = 1'b1;
            r.carry = (v >= 64'd16777216);
            r.expo  = 8'd255;
        end else if (v >= 64'd16777216) begin
            r.carry = 1'b1;
            r.mant  = 23'((v / 2) % 8388608);
            r.expo  = e + 8'd1;
        end else begin
            top  = $clog2(v + 1) - 1;
            need = 23 - top;
            lim  = (e == 8'd0) ? 0 : int'(e) - 1;
            sh   = (need <= lim) ? need : lim;
            r.shift = 8'(sh);
            r.mant  = 23'((v * (longint'(1) << sh)) % 8388608);
            if (need <= lim) begin
                r.expo = 8'(int'(e) - sh);
            end else begin
                r.unf  = 1'b1;
                r.expo = 8'd0;
            end
        end
        return r;
    endfunction

    function automatic logic [63:0] snap();
        return {18'd0, bus.mant_out, bus.exp_out, bus.norm_shift, bus.carry_out,
                bus.zero_flag, bus.underflow, bus.overflow, bus.sign_out};
    endfunction

    task automatic run_txn(input logic [24:0] s, input logic [7:0] e, input logic sg, input int hold);
        res_t        r;
        int          edges, lat;
        logic [63:0] exp_snap;
        r = model(s, e);
`ifdef NORM_LZC_EN
        lat = 1;
`else
        lat = 1 + int'(r.shift);
`endif
        exp_snap = {18'd0, r.mant, r.expo, r.shift, r.carry, r.zero, r.unf, r.ovf, sg};
        check("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.sum_in   = s;
        bus.exp_in   = e;
        bus.sign_in  = sg;
        @(posedge clk); #1;
        // Junk presented while busy must be ignored.
        bus.in_valid = 1'b1;
        bus.sum_in   = 25'($urandom);
        bus.exp_in   = 8'($urandom);
        bus.sign_in  = ~sg;
        edges = 0;
        while (!bus.out_valid && edges < 64) begin
            @(posedge clk); #1;
            edges++;
        end
        check("latency", edges, lat);
        check("mant_out", bus.mant_out, r.mant);
        check("exp_out", bus.exp_out, r.expo);
        check("norm_shift", bus.norm_shift, r.shift);
        check("flags", {bus.carry_out, bus.zero_flag, bus.underflow, bus.overflow},
              {r.carry, r.zero, r.unf, r.ovf});
        check("sign_out", bus.sign_out, sg);
        check("in_ready_done", bus.in_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", {bus.out_valid, bus.in_ready}, 2'b10);
            check("hold_stable", snap(), exp_snap);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        check("release", {bus.out_valid, bus.in_ready}, 2'b01);
    endtask

    task automatic rand_txn();
        logic [24:0] s;
        logic [7:0]  e;
        int          cat, pos;
        cat = $urandom_range(0, 9);
        if (cat == 0) begin
            s = '0;
        end else if (cat == 1) begin
            s = 25'h1000000 | 25'($urandom_range(0, 32'hFFFFFF));
        end else begin
            pos = $urandom_range(0, 23);
            s = 25'(32'h1 << pos) | 25'($urandom & ((32'h1 << pos) - 1));
        end
        cat = $urandom_range(0, 9);
        if (cat < 6)      e = 8'($urandom_range(1, 254));
        else if (cat < 9) e = 8'($urandom_range(0, 20));
        else              e = 8'($urandom_range(254, 255));
        run_txn(s, e, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    endtask

    initial begin
        int late_valid;
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sum_in    = '0;
        bus.exp_in    = '0;
        bus.sign_in   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", state_dbg, 0);
        check("rst_hs", {bus.out_valid, bus.in_ready}, 2'b01);
        check("rst_outputs", snap(), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(25'h0800000, 8'h80, 1'b0, 1);
        run_txn(25'h1000000, 8'h7F, 1'b1, 0);
        run_txn(25'h0000001, 8'h80, 1'b0, 0);
        run_txn(25'h0000100, 8'h03, 1'b1, 1);
        run_txn(25'h1800000, 8'hFE, 1'b0, 0);
        run_txn(25'h0800000, 8'hFF, 1'b1, 0);
        run_txn(25'h0000000, 8'h55, 1'b0, 5);
        run_txn(25'h0400000, 8'h01, 1'b0, 0);
        run_txn(25'h0400000, 8'h02, 1'b1, 0);

        for (int t = 0; t < 80; t++) rand_txn();

        // Reset in the middle of a long normalization.
        bus.in_valid = 1'b1;
        bus.sum_in   = 25'h0000001;
        bus.exp_in   = 8'h80;
        bus.sign_in  = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midnorm_state", state_dbg, 1);
        rst_n = 1'b0;
        #1;
        check("arst_state", state_dbg, 0);
        check("arst_hs", {bus.out_valid, bus.in_ready}, 2'b01);
        check("arst_outputs", snap(), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        late_valid = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) late_valid++;
        end
        check("no_valid_after_rst", late_valid, 0);
        run_txn(25'h0123456, 8'h40, 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/normalize_seq.md
NORMALIZE_SEQ -- requirements
Module: normalize_seq

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 in_valid  input  1  aligned sum presented.
REQ-004 in_ready  output  1  block can accept a sum; high only in IDLE.
REQ-005 sum_in  input  25  post-alignment adder sum; bit 24 = adder carry-out, bit 23 = hidden bit.
REQ-006 exp_in  input  8  larger operand's biased exponent.
REQ-007 sign_in  input  1  resultant sign from control stage; passed through.
REQ-008 out_valid  output  1  normalized result held stable until accepted.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 mant_out  output  23  normalized fraction, hidden bit dropped.
REQ-011 exp_out  output  8  corrected exponent.
REQ-012 sign_out  output  1  registered sign_in.
REQ-013 norm_shift  output  8  left-shift amount applied; 0 for carry or zero cases; feeds control stage exponent correction.
REQ-014 carry_out  output  1  result right-shifted one place due to carry.
REQ-015 zero_flag, underflow, overflow  output  1 each  result status.

Function
REQ-016 FSM states IDLE, NORM, DONE; no other reachable state.
REQ-017 IDLE: in_ready=1; on in_valid&&in_ready capture sum_in/exp_in/sign_in, clear norm_shift, go NORM.
REQ-018 NORM evaluation priority, one per cycle: (a) sum==0 -> DONE, zero_flag=1, exp_out=0, mant_out=0; (b) bit24=1 -> right shift 1, exp+1, carry_out=1, DONE; (c) bit23=1 -> DONE; (d) exp==1 -> DONE, exp_out=0, underflow=1, mantissa unshifted; (e) else left shift 1, exp-1, norm_shift+1, stay NORM.
REQ-019 Carry with exp_in==254 -> exp_out=255, mant_out=0, overflow=1; exp_in==255 on entry -> same overflow result.
REQ-020 Latency (default build): input accepted at edge k; out_valid asserted after edge k+1+n, n = left shifts performed (n≤23).
REQ-021 DONE: out_valid=1, all outputs stable; on out_ready go IDLE at next edge; out_valid and in_ready never both high.
REQ-022 No new input accepted before DONE->IDLE transition; in_valid ignored outside IDLE.
REQ-023 norm_shift saturates at 23; never wraps.
REQ-024 Status flags mutually exclusive except none set for normal result.

Reset
REQ-025 rst_n low asynchronously forces IDLE, in_ready=1 after release, out_valid=0, mant_out=0, exp_out=0, sign_out=0, norm_shift=0, carry_out=0, all flags 0.
REQ-026 Reset asserted in NORM or DONE discards the in-flight result; no out_valid pulse follows release.

Configuration
REQ-027 Macro NORM_LZC_EN: when defined, NORM uses single-cycle leading-zero count and barrel shift; every case completes NORM in exactly one cycle (out_valid after edge k+1), with identical results, flags and norm_shift value.
REQ-028 NORM_LZC_EN undefined: iterative one-bit-per-cycle shifting per REQ-018/020.
REQ-029 LZC shift limited to exp_in-1; excess -> underflow per REQ-018(d) with norm_shift = exp_in-1.

Verification
REQ-030 sum_in=0x0800000, exp_in=0x80, sign 0 -> one NORM cycle, mant_out=0, exp_out=0x80, norm_shift=0, no flags.
REQ-031 sum_in=0x1000000, exp_in=0x7F -> exp_out=0x80, mant_out=0, carry_out=1, norm_shift=0.
REQ-032 sum_in=0x0000001, exp_in=0x80 -> norm_shift=23, exp_out=0x69, mant_out=0; default build out_valid after 24 NORM edges, LZC build after 1.
REQ-033 sum_in=0x0000100, exp_in=0x03 -> underflow=1, exp_out=0, norm_shift=2; sum_in=0x1800000, exp_in=0xFE -> overflow=1, exp_out=0xFF, mant_out=0.
REQ-034 sum_in=0 -> zero_flag=1; hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0, extra in_valid ignored.
REQ-035 rst_n pulsed low mid-NORM (sum_in=0x0000001) -> immediate IDLE, all outputs reset, no out_valid after release.
